t07_mem_responder: RTL

T07_MEM_RESPONDER -- requirements
Module: t07_mem_responder

---
 rtl/t07_mem_responder_if.sv | 30 +++
 rtl/t07_mem_responder.sv | 85 ++++++++
 2 files changed

// File: rtl/t07_mem_responder_if.sv
// t07_mem_responder_if: CPU-side request signals and
// downstream single-beat bus signals of the memory responder.
interface t07_mem_responder_if;
  logic [1:0]  rwi;
  logic [31:0] ext_address;
  logic [31:0] write_data;
  logic        busy;
  logic [31:0] ext_data;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        err_timeout;

  modport slave (
    input  rwi, ext_address, write_data,
    input  bus_ack, bus_rdata,
    output busy, ext_data, err_timeout,
    output bus_req, bus_we, bus_addr, bus_wdata
  );

  modport master (
    output rwi, ext_address, write_data,
    output bus_ack, bus_rdata,
    input  busy, ext_data, err_timeout,
    input  bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/t07_mem_responder.sv
// t07_mem_responder: turns a CPU rwi request into one
// bus_req pulse, waits for bus_ack or timeout, returns data.
module t07_mem_responder #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic                  clk,
  input logic                  rst,
  t07_mem_responder_if.slave   mem
);
  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, DONE
  } state_t;

  localparam logic [7:0] TMAX = 8'(TIMEOUT);

  state_t     state;
  logic [7:0] cnt;
  logic       is_rd;
  logic [1:0] off;

  logic [31:0] rd_shift;
  assign rd_shift = mem.bus_rdata >> {off, 3'b000};

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      is_rd           <= 1'b0;
      off             <= '0;
      mem.busy        <= 1'b0;
      mem.bus_req     <= 1'b0;
      mem.bus_we      <= 1'b0;
      mem.bus_addr    <= '0;
      mem.bus_wdata   <= '0;
      mem.ext_data    <= '0;
      mem.err_timeout <= 1'b0;
    end else begin
      mem.bus_req     <= 1'b0;
      mem.err_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem.rwi == 2'b01 || mem.rwi == 2'b10) begin
            state         <= REQ;
            mem.busy      <= 1'b1;
            mem.bus_req   <= 1'b1;
            mem.bus_we    <= (mem.rwi == 2'b01);
            mem.bus_addr  <= {mem.ext_address[31:2], 2'b00};
            mem.bus_wdata <= mem.write_data;
            is_rd         <= (mem.rwi == 2'b10);
            off           <= mem.ext_address[1:0];
          end
        end
        REQ: begin
          if (mem.bus_ack) begin
            state    <= DONE;
            mem.busy <= 1'b0;
            if (is_rd) mem.ext_data <= rd_shift;
          end else begin
            state <= WAIT;
            cnt   <= 8'd1;
          end
        end
        WAIT: begin
          if (mem.bus_ack) begin
            state    <= DONE;
            mem.busy <= 1'b0;
            cnt      <= '0;
            if (is_rd) mem.ext_data <= rd_shift;
          end else if (cnt == TMAX) begin
            state           <= DONE;
            mem.busy        <= 1'b0;
            mem.err_timeout <= 1'b1;
            cnt             <= '0;
            if (is_rd) mem.ext_data <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        // rwi deliberately ignored: CPU still holds its request here
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
